// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the core MEM stage and the
// host/loader bridge. The arbiter owns the BRAM port (enable, write enable,
// word address, write data), routes the one-cycle-latency read data back to
// whichever requester issued the read, and stalls the core whenever it asks
// for the memory but does not get it.
//
// The host can take exclusive ownership with host_lock. The arbiter then moves
// NORMAL -> LOCK_PEND -> LOCKED:
//   - LOCK_PEND lets a core read issued in the last NORMAL cycle drain.
//   - LOCKED holds the core off so the host can bulk load or inspect memory.
//
// Build option:
//   DMEM_ARB_FAIR_EN  When defined, a saturating wait counter forces one host
//                     grant after HOST_MAX_WAIT consecutive denied host cycles
//                     in NORMAL. When undefined, the core always wins in NORMAL
//                     and the host can starve.
//
// Parameters:
//   ADDR_W         word-address width of the data memory
//   DATA_W         data width
//   HOST_MAX_WAIT  denied host cycles before a forced host grant (fair build)
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   core_req/we/addr/wdata             core request (held until core_gnt)
//   core_gnt, core_stall               core issued this cycle / core stalled
//   core_rvalid, core_rdata            core read return, one cycle after grant
//   host_req/we/addr/wdata             host request (held until host_gnt)
//   host_lock                          host asks for exclusive ownership
//   host_gnt                           host issued this cycle
//   host_rvalid, host_rdata            host read return, one cycle after grant
//   locked                             arbiter is in LOCKED
//   mem_en/we/addr/wdata               BRAM port, driven by the granted side
//   mem_rdata                          BRAM read data, one cycle after issue
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W        = 13,
  parameter int DATA_W        = 32,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,

  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,

  output logic              locked,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_LOCK_PEND = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t state_reg;
  logic   locked_reg;
  logic   rd_core_reg;
  logic   rd_host_reg;
  logic   host_force;

  // ---------------------------------------------------------------------------
  // Host starvation guard
  // ---------------------------------------------------------------------------
`ifdef DMEM_ARB_FAIR_EN
  localparam int CNT_W = (HOST_MAX_WAIT < 1) ? 1 : $clog2(HOST_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOST_MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_reg;

  // Counts consecutive cycles the host asked and was refused. Any grant or a
  // dropped request starts the count over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
    end else if (!host_req || host_gnt) begin
      wait_cnt_reg <= '0;
    end else if (wait_cnt_reg != CNT_MAX) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  assign host_force = (state_reg == ST_NORMAL) && host_req &&
                      (wait_cnt_reg == CNT_MAX);
`else
  assign host_force = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Grant decision (same cycle as the request)
  // ---------------------------------------------------------------------------
  // Grants are also held off while rst_n is low, so a requester that keeps
  // asking through reset can never write memory during reset.
  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (rst_n) begin
      case (state_reg)
        ST_NORMAL: begin
          if (host_force) begin
            host_gnt = 1'b1;
          end else if (core_req) begin
            core_gnt = 1'b1;
          end else begin
            host_gnt = host_req;
          end
        end
        // LOCK_PEND and LOCKED: the core is held off, the host is served.
        default: begin
          host_gnt = host_req;
        end
      endcase
    end
  end

  assign core_stall = core_req & ~core_gnt;

  // ---------------------------------------------------------------------------
  // BRAM port mux: the granted side drives it, everything is zero otherwise
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = core_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM and read-return tags
  // ---------------------------------------------------------------------------
  // The tags record who issued the read that mem_rdata will carry next cycle.
  // Only one grant exists per cycle, so at most one tag is set at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_NORMAL;
      locked_reg  <= 1'b0;
      rd_core_reg <= 1'b0;
      rd_host_reg <= 1'b0;
    end else begin
      rd_core_reg <= core_gnt & ~core_we;
      rd_host_reg <= host_gnt & ~host_we;

      case (state_reg)
        ST_NORMAL: begin
          if (host_lock) begin
            state_reg  <= ST_LOCK_PEND;
            locked_reg <= 1'b0;
          end
        end
        // One cycle with no core grant lets the last core read return
        // before the host is told it owns the memory.
        ST_LOCK_PEND: begin
          if (host_lock) begin
            state_reg  <= ST_LOCKED;
            locked_reg <= 1'b1;
          end else begin
            state_reg  <= ST_NORMAL;
            locked_reg <= 1'b0;
          end
        end
        ST_LOCKED: begin
          if (!host_lock) begin
            state_reg  <= ST_NORMAL;
            locked_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= ST_NORMAL;
          locked_reg <= 1'b0;
        end
      endcase
    end
  end

  assign locked      = locked_reg;
  assign core_rvalid = rd_core_reg;
  assign host_rvalid = rd_host_reg;

  // Both sides see the raw BRAM data; each qualifies it with its own rvalid.
  assign core_rdata  = mem_rdata;
  assign host_rdata  = mem_rdata;

endmodule
